// File: rtl/srio_pkg.sv
// srio_pkg
//   Shared definitions for the SRIO SWRITE packer/unpacker pair:
//   - FTYPE_SWRITE            : HELLO FTYPE code for streaming writes
//   - HELLO_*                 : bit positions of the HELLO header fields
//   - state_e                 : unpacker packet-level states
//   - hello_last_keep()       : TKEEP for the final payload beat of a packet
package srio_pkg;

  localparam logic [3:0] FTYPE_SWRITE = 4'd6;

  // HELLO header field positions within the 64-bit header beat
  localparam int unsigned HELLO_FTYPE_MSB = 55;
  localparam int unsigned HELLO_FTYPE_LSB = 52;
  localparam int unsigned HELLO_TTYPE_MSB = 51;
  localparam int unsigned HELLO_TTYPE_LSB = 48;
  localparam int unsigned HELLO_SIZE_MSB  = 43;
  localparam int unsigned HELLO_SIZE_LSB  = 36;
  localparam int unsigned HELLO_ADDR_MSB  = 33;
  localparam int unsigned HELLO_ADDR_LSB  = 0;

  typedef enum logic [1:0] {
    HDR,
    DATA,
    DRAIN
  } state_e;

  // SIZE is (bytes - 1); the final beat carries SIZE[2:0]+1 bytes packed
  // MSB-first, so a shift of 8 (full beat) yields all ones.
  function automatic logic [7:0] hello_last_keep(input logic [2:0] size_lsb);
    logic [3:0] nbytes;
    nbytes = {1'b0, size_lsb} + 4'd1;
    return ~(8'hFF >> nbytes);
  endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// axis_pipe_reg
//   Single-stage AXI-Stream register slice for a 64-bit data path with
//   8-bit TKEEP, TLAST and a 32-bit TUSER sideband.
//   Ports:
//     clk_i, rst_ni              clock, synchronous active-low reset
//     in_valid_i / in_ready_o    upstream handshake (ready = !valid || out_ready)
//     in_data_i/keep_i/last_i    beat payload, captured on upstream handshake
//     user_ld_i, in_user_i       TUSER load strobe and value
//     out_valid_o / out_ready_i  downstream handshake
//     out_data_o/keep_o/last_o/user_o  registered beat
module axis_pipe_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] in_data_i,
  input  logic [7:0]  in_keep_i,
  input  logic        in_last_i,
  input  logic        user_ld_i,
  input  logic [31:0] in_user_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_data_o,
  output logic [7:0]  out_keep_o,
  output logic        out_last_o,
  output logic [31:0] out_user_o
);

  logic        valid_q;
  logic [63:0] data_q;
  logic [7:0]  keep_q;
  logic        last_q;
  logic [31:0] user_q;
  logic        in_hs;

  assign in_ready_o = !valid_q || out_ready_i;
  assign in_hs      = in_valid_i && in_ready_o;

  // TUSER has its own load strobe so a per-packet value can be latched
  // before the first beat and held constant for the whole packet. Callers
  // must only pulse user_ld_i while in_ready_o is high to keep it stable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
    end else begin
      if (in_ready_o) begin
        valid_q <= in_valid_i;
      end
      if (in_hs) begin
        data_q <= in_data_i;
        keep_q <= in_keep_i;
        last_q <= in_last_i;
      end
      if (user_ld_i) begin
        user_q <= in_user_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_keep_o  = keep_q;
  assign out_last_o  = last_q;
  assign out_user_o  = user_q;

endmodule

// File: rtl/srio_swrite_unpack.sv
// srio_swrite_unpack
//   Receives HELLO-format SRIO packets, keeps SWRITE packets addressed to
//   this endpoint, strips the header and forwards the payload as 64-bit
//   AXI-Stream with TKEEP on the last beat.
//   Ports:
//     AXIS_ACLK, AXIS_ARESETN     clock, synchronous active-low reset
//     S_AXIS_*                    HELLO stream from the SRIO core
//                                 (TUSER = {src_id, dest_id} on header beat)
//     M_AXIS_*                    payload stream, TUSER = latched srcdest
//     cfg_dest_id, cfg_filter_en  endpoint ID and destination filter enable
//     hdr_addr, hdr_valid         latched address, pulse on accepted header
//     pkt_cnt, drop_cnt, err_cnt  wrapping good/filtered/malformed counters
//     dbug_*                      mirrors of the four handshake signals
module srio_swrite_unpack
  import srio_pkg::*;
(
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESETN,

  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [63:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic [31:0] S_AXIS_TUSER,

  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [63:0] M_AXIS_TDATA,
  output logic [7:0]  M_AXIS_TKEEP,
  output logic        M_AXIS_TLAST,
  output logic [31:0] M_AXIS_TUSER,

  input  logic [15:0] cfg_dest_id,
  input  logic        cfg_filter_en,

  output logic [33:0] hdr_addr,
  output logic        hdr_valid,
  output logic [31:0] pkt_cnt,
  output logic [31:0] drop_cnt,
  output logic [31:0] err_cnt,

  output logic        dbug_m_rdy,
  output logic        dbug_m_vld,
  output logic        dbug_s_rdy,
  output logic        dbug_s_vld
);

  state_e      state_q;
  logic [5:0]  beat_cnt_q;
  logic [2:0]  size_lsb_q;
  logic [33:0] addr_q;
  logic        hdr_valid_q;
  logic [31:0] pkt_cnt_q;
  logic [31:0] drop_cnt_q;
  logic [31:0] err_cnt_q;

  logic        pipe_in_ready;
  logic        pipe_in_valid;
  logic        pipe_in_last;
  logic [7:0]  pipe_in_keep;

  logic        s_hs;
  logic        hdr_hs;
  logic        data_hs;
  logic        hdr_accept;
  logic        dest_ok;
  logic        is_swrite;
  logic        cnt_one;
  logic [3:0]  hdr_ftype;
  logic [7:0]  hdr_size;
  logic [5:0]  hdr_beats;

  assign hdr_ftype = S_AXIS_TDATA[HELLO_FTYPE_MSB:HELLO_FTYPE_LSB];
  assign hdr_size  = S_AXIS_TDATA[HELLO_SIZE_MSB:HELLO_SIZE_LSB];
  assign hdr_beats = {1'b0, hdr_size[7:3]} + 6'd1;

  assign is_swrite = (hdr_ftype == FTYPE_SWRITE);
  assign dest_ok   = !cfg_filter_en || (S_AXIS_TUSER[15:0] == cfg_dest_id);

  // HDR also waits on the output register so a header is never taken while
  // the previous packet's final beat is still stalled downstream.
  assign S_AXIS_TREADY = (state_q == DRAIN) ? 1'b1 : pipe_in_ready;

  assign s_hs       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign hdr_hs     = (state_q == HDR) && s_hs;
  assign data_hs    = (state_q == DATA) && s_hs;
  assign hdr_accept = hdr_hs && !S_AXIS_TLAST && is_swrite && dest_ok;
  assign cnt_one    = (beat_cnt_q == 6'd1);

  // A beat closes the output packet either on input TLAST (good or short)
  // or when the expected count runs out (good or long); only the count-based
  // end knows the true byte count, so a short packet ends with a full TKEEP.
  assign pipe_in_valid = (state_q == DATA) && S_AXIS_TVALID;
  assign pipe_in_last  = S_AXIS_TLAST || cnt_one;
  assign pipe_in_keep  = cnt_one ? hello_last_keep(size_lsb_q) : '1;

  axis_pipe_reg u_pipe (
    .clk_i       (AXIS_ACLK),
    .rst_ni      (AXIS_ARESETN),
    .in_valid_i  (pipe_in_valid),
    .in_ready_o  (pipe_in_ready),
    .in_data_i   (S_AXIS_TDATA),
    .in_keep_i   (pipe_in_keep),
    .in_last_i   (pipe_in_last),
    .user_ld_i   (hdr_accept),
    .in_user_i   (S_AXIS_TUSER),
    .out_valid_o (M_AXIS_TVALID),
    .out_ready_i (M_AXIS_TREADY),
    .out_data_o  (M_AXIS_TDATA),
    .out_keep_o  (M_AXIS_TKEEP),
    .out_last_o  (M_AXIS_TLAST),
    .out_user_o  (M_AXIS_TUSER)
  );

  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state_q     <= HDR;
      beat_cnt_q  <= '0;
      size_lsb_q  <= '0;
      addr_q      <= '0;
      hdr_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      hdr_valid_q <= hdr_accept;
      unique case (state_q)
        HDR: begin
          if (hdr_hs) begin
            if (S_AXIS_TLAST) begin
              err_cnt_q <= err_cnt_q + 32'd1;
            end else if (hdr_accept) begin
              size_lsb_q <= hdr_size[2:0];
              addr_q     <= S_AXIS_TDATA[HELLO_ADDR_MSB:HELLO_ADDR_LSB];
              beat_cnt_q <= hdr_beats;
              state_q    <= DATA;
            end else begin
              drop_cnt_q <= drop_cnt_q + 32'd1;
              state_q    <= DRAIN;
            end
          end
        end
        DATA: begin
          if (data_hs) begin
            beat_cnt_q <= beat_cnt_q - 6'd1;
            if (S_AXIS_TLAST) begin
              state_q <= HDR;
              if (cnt_one) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
              end else begin
                err_cnt_q <= err_cnt_q + 32'd1;
              end
            end else if (cnt_one) begin
              err_cnt_q <= err_cnt_q + 32'd1;
              state_q   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (s_hs && S_AXIS_TLAST) begin
            state_q <= HDR;
          end
        end
        default: state_q <= HDR;
      endcase
    end
  end

  assign hdr_addr  = addr_q;
  assign hdr_valid = hdr_valid_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_cnt   = err_cnt_q;

  assign dbug_m_rdy = M_AXIS_TREADY;
  assign dbug_m_vld = M_AXIS_TVALID;
  assign dbug_s_rdy = S_AXIS_TREADY;
  assign dbug_s_vld = S_AXIS_TVALID;

endmodule

// File: tb/tb_srio_swrite_unpack.sv
module tb_srio_swrite_unpack;

  localparam logic [15:0] MY_ID = 16'h00A5;

  logic        clk = 1'b0;
  logic        AXIS_ARESETN;
  logic        S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
  logic [63:0] S_AXIS_TDATA;
  logic [31:0] S_AXIS_TUSER;
  logic        M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic [63:0] M_AXIS_TDATA;
  logic [7:0]  M_AXIS_TKEEP;
  logic [31:0] M_AXIS_TUSER;
  logic [15:0] cfg_dest_id;
  logic        cfg_filter_en;
  logic [33:0] hdr_addr;
  logic        hdr_valid;
  logic [31:0] pkt_cnt, drop_cnt, err_cnt;
  logic        dbug_m_rdy, dbug_m_vld, dbug_s_rdy, dbug_s_vld;

  always #5 clk = ~clk;

  srio_swrite_unpack dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (AXIS_ARESETN),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TUSER  (S_AXIS_TUSER),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .cfg_dest_id   (cfg_dest_id),
    .cfg_filter_en (cfg_filter_en),
    .hdr_addr      (hdr_addr),
    .hdr_valid     (hdr_valid),
    .pkt_cnt       (pkt_cnt),
    .drop_cnt      (drop_cnt),
    .err_cnt       (err_cnt),
    .dbug_m_rdy    (dbug_m_rdy),
    .dbug_m_vld    (dbug_m_vld),
    .dbug_s_rdy    (dbug_s_rdy),
    .dbug_s_vld    (dbug_s_vld)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [31:0] user;
  } beat_t;

  typedef struct {
    string      name;
    logic [3:0] ft;
    logic [7:0] sz;
    logic       mism;
    logic       filt;
    int         npay;
    int         exp_beats;
    logic [7:0] exp_keep;
    int         d_pkt;
    int         d_drop;
    int         d_err;
  } vec_t;

  beat_t       exp_q[$];
  logic [65:0] hdr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          obs_cnt = 0;
  logic [7:0]  obs_keep = '0;
  int          rdy_mode = 0;
  logic [31:0] m_pkt = '0, m_drop = '0, m_err = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pk(input beat_t b);
    return 128'({b.data, b.keep, b.last, b.user});
  endfunction

  // MSB-first byte mask: byte j of the beat lives in bits [63-8j -: 8]
  function automatic logic [7:0] keep_of(input int nbytes);
    logic [7:0] m;
    m = '0;
    for (int j = 0; j < nbytes; j++) m[7-j] = 1'b1;
    return m;
  endfunction

  task automatic monitor();
    beat_t b, e, prev;
    logic held;
    logic [65:0] h;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!AXIS_ARESETN) begin
        held = 1'b0;
      end else begin
        b = '{M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER};
        if (held) chk("hold", {M_AXIS_TVALID, pk(b)[126:0]}, {1'b1, pk(prev)[126:0]});
        held = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev = b;
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          obs_cnt++;
          obs_keep = b.keep;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL beat: unexpected output beat data=%h keep=%h last=%b", b.data, b.keep, b.last);
          end else begin
            e = exp_q.pop_front();
            chk("beat", pk(b), pk(e));
          end
        end
        if (hdr_valid) begin
          if (hdr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL hdr: unexpected hdr_valid addr=%h", hdr_addr);
          end else begin
            h = hdr_q.pop_front();
            chk("hdr", 128'({hdr_addr, M_AXIS_TUSER}), 128'(h));
          end
        end
      end
      @(posedge clk); #1;
      case (rdy_mode)
        0:       M_AXIS_TREADY = 1'b1;
        1:       M_AXIS_TREADY = ($urandom % 3) != 0;
        default: M_AXIS_TREADY = 1'b0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [31:0] u, input logic l);
    int   t;
    logic ok;
    t = 0;
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = d; S_AXIS_TUSER = u; S_AXIS_TLAST = l;
    do begin
      @(negedge clk);
      ok = S_AXIS_TREADY;
      t++;
      if (!ok) tick();
    end while (!ok && t < 1000);
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL s_ready_timeout: got 0 expected 1 within 1000 cycles");
    end else begin
      tick();
    end
    S_AXIS_TVALID = 1'b0;
  endtask

  // Reference model: decides the packet's fate from the header rules and
  // queues the beats and header event it must produce, then drives it.
  task automatic send_pkt(input logic [3:0] ft, input logic [7:0] sz, input logic [15:0] dst,
                          input logic filt, input int npay);
    logic [63:0] pay[$];
    logic [63:0] hdr, r;
    logic [33:0] ad;
    logic [15:0] src;
    int n, k, nout;
    beat_t e;
    r   = {$urandom, $urandom};
    ad  = r[33:0];
    src = 16'($urandom);
    for (int i = 0; i < npay; i++) pay.push_back({$urandom, $urandom});
    cfg_filter_en = filt;
    if (npay == 0) begin
      m_err++;
    end else if (ft != 4'd6 || (filt && dst != MY_ID)) begin
      m_drop++;
    end else begin
      n = int'(sz) / 8 + 1;
      k = int'(sz) % 8 + 1;
      nout = (npay < n) ? npay : n;
      hdr_q.push_back({ad, src, dst});
      for (int i = 0; i < nout; i++) begin
        e.data = pay[i];
        e.last = (i == nout - 1);
        e.keep = (e.last && npay >= n) ? keep_of(k) : 8'hFF;
        e.user = {src, dst};
        exp_q.push_back(e);
      end
      if (npay == n) m_pkt++; else m_err++;
    end
    hdr = '0;
    hdr[55:52] = ft;
    hdr[43:36] = sz;
    hdr[33:0]  = ad;
    drive_beat(hdr, {src, dst}, npay == 0);
    for (int i = 0; i < npay; i++) begin
      if (rdy_mode == 1 && ($urandom % 4) == 0) tick();
      drive_beat(pay[i], $urandom, i == npay - 1);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || hdr_q.size() != 0 || M_AXIS_TVALID) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    tick(); tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_m_valid"}, 128'(M_AXIS_TVALID), 128'(0));
    chk({tag, "_m_beat"}, 128'({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER}), 128'(0));
    chk({tag, "_hdr"}, 128'({hdr_addr, hdr_valid}), 128'(0));
    chk({tag, "_cnts"}, 128'({pkt_cnt, drop_cnt, err_cnt}), 128'(0));
    chk({tag, "_s_ready"}, 128'(S_AXIS_TREADY), 128'(1));
  endtask

  vec_t vecs[10];

  initial begin
    int t_pkt, t_drop, t_err;
    logic [63:0] r;
    logic [3:0]  ft;
    logic [7:0]  sz;
    logic [15:0] dst;
    int n, np, sel;

    vecs[0] = '{"swr32",     4'd6, 8'd31,  1'b0, 1'b1, 4,  4,  8'hFF, 1, 0, 0};
    vecs[1] = '{"swr13",     4'd6, 8'd12,  1'b0, 1'b1, 2,  2,  8'hF8, 1, 0, 0};
    vecs[2] = '{"ftype5",    4'd5, 8'd31,  1'b0, 1'b1, 4,  0,  8'h00, 0, 1, 0};
    vecs[3] = '{"filt_drop", 4'd6, 8'd15,  1'b1, 1'b1, 2,  0,  8'h00, 0, 1, 0};
    vecs[4] = '{"filt_off",  4'd6, 8'd15,  1'b1, 1'b0, 2,  2,  8'hFF, 1, 0, 0};
    vecs[5] = '{"short",     4'd6, 8'd63,  1'b0, 1'b1, 3,  3,  8'hFF, 0, 0, 1};
    vecs[6] = '{"long",      4'd6, 8'd7,   1'b0, 1'b1, 3,  1,  8'hFF, 0, 0, 1};
    vecs[7] = '{"hdr_only",  4'd6, 8'd7,   1'b0, 1'b1, 0,  0,  8'h00, 0, 0, 1};
    vecs[8] = '{"one_byte",  4'd6, 8'd0,   1'b0, 1'b1, 1,  1,  8'h80, 1, 0, 0};
    vecs[9] = '{"size255",   4'd6, 8'd255, 1'b0, 1'b1, 32, 32, 8'hFF, 1, 0, 0};

    AXIS_ARESETN = 1'b0;
    S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 1'b0; S_AXIS_TUSER = '0;
    M_AXIS_TREADY = 1'b1;
    cfg_dest_id = MY_ID; cfg_filter_en = 1'b1;
    fork monitor(); join_none
    repeat (3) tick();
    chk_reset_state("rst");
    AXIS_ARESETN = 1'b1;
    tick();

    // Table vectors: pass 0 with M always ready, pass 1 with random stalls
    t_pkt = 0; t_drop = 0; t_err = 0;
    for (int pass = 0; pass < 2; pass++) begin
      rdy_mode = pass;
      tick(); tick();
      for (int v = 0; v < 10; v++) begin
        obs_cnt = 0;
        send_pkt(vecs[v].ft, vecs[v].sz, vecs[v].mism ? (MY_ID ^ 16'h0100) : MY_ID,
                 vecs[v].filt, vecs[v].npay);
        wait_idle();
        t_pkt += vecs[v].d_pkt; t_drop += vecs[v].d_drop; t_err += vecs[v].d_err;
        chk({vecs[v].name, "_beats"}, 128'(obs_cnt), 128'(vecs[v].exp_beats));
        if (vecs[v].exp_beats > 0) chk({vecs[v].name, "_last_keep"}, 128'(obs_keep), 128'(vecs[v].exp_keep));
        chk({vecs[v].name, "_cnts"}, 128'({pkt_cnt, drop_cnt, err_cnt}),
            128'({32'(t_pkt), 32'(t_drop), 32'(t_err)}));
      end
    end

    // Reset while a payload beat is stalled in the output register
    rdy_mode = 2;
    tick(); tick();
    r = {$urandom, $urandom};
    hdr_q.push_back({r[33:0], 16'h1234, MY_ID});
    r[63:34] = '0;
    r[55:52] = 4'd6;
    r[43:36] = 8'd31;
    drive_beat(r, {16'h1234, MY_ID}, 1'b0);
    drive_beat({$urandom, $urandom}, $urandom, 1'b0);
    chk("pend_valid", 128'(M_AXIS_TVALID), 128'(1));
    AXIS_ARESETN = 1'b0;
    tick();
    chk_reset_state("mid_rst");
    AXIS_ARESETN = 1'b1;
    m_pkt = '0; m_drop = '0; m_err = '0;
    exp_q.delete();
    rdy_mode = 0;
    tick(); tick();
    obs_cnt = 0;
    send_pkt(4'd6, 8'd31, MY_ID, 1'b1, 4);
    wait_idle();
    chk("post_rst_beats", 128'(obs_cnt), 128'(4));
    chk("post_rst_cnts", 128'({pkt_cnt, drop_cnt, err_cnt}), 128'({32'd1, 32'd0, 32'd0}));

    // Randomized packets against the reference model
    rdy_mode = 1;
    for (int p = 0; p < 60; p++) begin
      ft  = (($urandom % 5) == 0) ? 4'($urandom) : 4'd6;
      sz  = 8'($urandom);
      dst = (($urandom % 4) == 0) ? 16'($urandom) : MY_ID;
      n   = int'(sz) / 8 + 1;
      sel = $urandom % 6;
      case (sel)
        0:       np = 0;
        1:       np = (n > 1) ? n - 1 : n;
        2:       np = n + 1 + ($urandom % 2);
        default: np = n;
      endcase
      send_pkt(ft, sz, dst, 1'($urandom), np);
      wait_idle();
      chk("rand_cnts", 128'({pkt_cnt, drop_cnt, err_cnt}), 128'({m_pkt, m_drop, m_err}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
